// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: timed multi-phase wash sequencer with pause/abort,
// a seconds prescaler, water-level thermometer and end-of-cycle buzzer.
module wash_cycle_ctrl #(
    parameter int N_PHASES = 4,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 100_000_000,
    parameter int WT_W     = 8,
    parameter int BUZZ_SEC = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        abort,
    input  logic [N_PHASES-1:0]         phase_mask,
    input  logic [N_PHASES*CNT_W-1:0]   phase_dur,
    output logic                        busy,
    output logic                        paused,
    output logic [$clog2(N_PHASES)-1:0] phase,
    output logic [CNT_W-1:0]            remain,
    output logic [N_PHASES-1:0]         st_light,
    output logic [WT_W-1:0]             wt_light,
    output logic                        done,
    output logic                        buzzer
);
    localparam int PW  = $clog2(N_PHASES);
    localparam int PSW = $clog2(TICK_DIV);
    localparam int BW  = $clog2(BUZZ_SEC + 1);
    localparam logic [PSW-1:0] PS_LAST   = PSW'(TICK_DIV - 1);
    localparam logic [BW-1:0]  BUZZ_LOAD = BW'(BUZZ_SEC);
    localparam logic [PW-1:0]  LAST_PH   = PW'(N_PHASES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t                    state_q, state_d;
    logic [N_PHASES-1:0]       act_q, act_d;
    logic [N_PHASES*CNT_W-1:0] dur_q, dur_d;
    logic [PSW-1:0]            presc_q, presc_d;
    logic [PW-1:0]             phase_q, phase_d;
    logic [CNT_W-1:0]          remain_q, remain_d;
    logic [WT_W-1:0]           wt_q, wt_d;
    logic [BW-1:0]             buzz_q, buzz_d;
    logic                      done_q, done_d;

    logic [N_PHASES-1:0] new_act;
    logic [PW-1:0]       first_idx, next_idx;
    logic                next_ok;
    logic                tick;

    assign tick = (presc_q == PS_LAST);

    // Active = enabled and nonzero duration; find first active at start
    // and the next active above the current phase while running.
    always_comb begin
        new_act   = '0;
        first_idx = '0;
        next_idx  = '0;
        next_ok   = 1'b0;
        for (int i = 0; i < N_PHASES; i++) begin
            new_act[i] = phase_mask[i] &&
                         (phase_dur[i*CNT_W +: CNT_W] != '0);
        end
        for (int i = N_PHASES - 1; i >= 0; i--) begin
            if (new_act[i]) first_idx = PW'(i);
            if (act_q[i] && i > int'(phase_q)) begin
                next_idx = PW'(i);
                next_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        dur_d    = dur_q;
        presc_d  = presc_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        wt_d     = wt_q;
        buzz_d   = buzz_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                presc_d  = '0;
                phase_d  = '0;
                remain_d = '0;
                wt_d     = '0;
                buzz_d   = '0;
                if (start && (|new_act)) begin
                    state_d  = RUN;
                    act_d    = new_act;
                    dur_d    = phase_dur;
                    phase_d  = first_idx;
                    remain_d = phase_dur[first_idx*CNT_W +: CNT_W];
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (phase_q == '0)
                        wt_d = {wt_q[WT_W-2:0], 1'b1};
                    else if (phase_q == LAST_PH)
                        wt_d = {1'b0, wt_q[WT_W-1:1]};
                    if (remain_q > CNT_W'(1)) begin
                        remain_d = remain_q - 1'b1;
                    end else if (next_ok) begin
                        phase_d  = next_idx;
                        remain_d = dur_q[next_idx*CNT_W +: CNT_W];
                    end else begin
                        state_d  = ALARM;
                        done_d   = 1'b1;
                        remain_d = '0;
                        buzz_d   = BUZZ_LOAD;
                    end
                end
                // A tick that finishes the cycle wins over a pause.
                if (pause && state_d == RUN) state_d = PAUSE;
            end
            PAUSE: begin
                if (pause) state_d = RUN;
            end
            ALARM: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (buzz_q <= BW'(1)) begin
                        state_d = IDLE;
                        buzz_d  = '0;
                        wt_d    = '0;
                        phase_d = '0;
                    end else begin
                        buzz_d = buzz_q - 1'b1;
                    end
                end
            end
        endcase
        if (abort) begin
            state_d  = IDLE;
            presc_d  = '0;
            phase_d  = '0;
            remain_d = '0;
            wt_d     = '0;
            buzz_d   = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            act_q    <= '0;
            dur_q    <= '0;
            presc_q  <= '0;
            phase_q  <= '0;
            remain_q <= '0;
            wt_q     <= '0;
            buzz_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            dur_q    <= dur_d;
            presc_q  <= presc_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            wt_q     <= wt_d;
            buzz_q   <= buzz_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign paused   = (state_q == PAUSE);
    assign phase    = phase_q;
    assign remain   = remain_q;
    assign wt_light = wt_q;
    assign done     = done_q;
    assign buzzer   = (state_q == ALARM);

    always_comb begin
        st_light = '0;
        if (state_q == RUN || state_q == PAUSE) st_light[phase_q] = 1'b1;
    end
endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// tb_wash_cycle_ctrl: directed and random stimulus against a model that
// derives outputs from elapsed run time and cumulative phase durations.
module tb_wash_cycle_ctrl;
    localparam int NP = 4;
    localparam int CW = 8;
    localparam int TD = 4;
    localparam int WW = 8;
    localparam int BZ = 3;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_ALARM = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic abort = 1'b0;
    logic [NP-1:0] phase_mask = '0;
    logic [NP*CW-1:0] phase_dur = '0;
    logic busy, paused, done, buzzer;
    logic [1:0] phase;
    logic [CW-1:0] remain;
    logic [NP-1:0] st_light;
    logic [WW-1:0] wt_light;

    wash_cycle_ctrl #(
        .N_PHASES(NP), .CNT_W(CW), .TICK_DIV(TD),
        .WT_W(WW), .BUZZ_SEC(BZ)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .abort(abort), .phase_mask(phase_mask),
        .phase_dur(phase_dur), .busy(busy), .paused(paused),
        .phase(phase), .remain(remain), .st_light(st_light),
        .wt_light(wt_light), .done(done), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: state, latched active durations, run cycles, alarm cycles.
    int m_st = 0, m_rc = 0, m_ac = 0;
    bit m_done = 0;
    int m_d [NP];
    int n_st, n_rc, n_ac, tot_n, any_n, dv;
    bit n_done;
    int n_d [NP];

    initial for (int i = 0; i < NP; i++) m_d[i] = 0;

    always_comb begin
        n_st = m_st;
        n_rc = m_rc;
        n_ac = m_ac;
        n_done = 1'b0;
        n_d = m_d;
        tot_n = 0;
        any_n = 0;
        dv = 0;
        for (int i = 0; i < NP; i++) tot_n += m_d[i];
        if (abort) begin
            n_st = S_IDLE;
        end else begin
            case (m_st)
                S_IDLE: if (start) begin
                    for (int i = 0; i < NP; i++) begin
                        dv = int'(phase_dur[i*CW +: CW]);
                        n_d[i] = (phase_mask[i] && dv != 0) ? dv : 0;
                        if (n_d[i] != 0) any_n = 1;
                    end
                    if (any_n != 0) begin
                        n_st = S_RUN;
                        n_rc = 0;
                    end else begin
                        n_d = m_d;
                    end
                end
                S_RUN: begin
                    n_rc = m_rc + 1;
                    if (n_rc == tot_n * TD) begin
                        n_st = S_ALARM;
                        n_ac = 0;
                        n_done = 1'b1;
                    end else if (pause) begin
                        n_st = S_PAUSE;
                    end
                end
                S_PAUSE: if (pause) n_st = S_RUN;
                S_ALARM: begin
                    n_ac = m_ac + 1;
                    if (n_ac == BZ * TD) n_st = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= S_IDLE;
            m_rc <= 0;
            m_ac <= 0;
            m_done <= 1'b0;
            for (int i = 0; i < NP; i++) m_d[i] <= 0;
        end else begin
            m_st <= n_st;
            m_rc <= n_rc;
            m_ac <= n_ac;
            m_done <= n_done;
            m_d <= n_d;
        end
    end

    logic e_busy, e_paused, e_done, e_buzz;
    logic [1:0] e_phase;
    logic [CW-1:0] e_remain;
    logic [NP-1:0] e_st;
    logic [WW-1:0] e_wt;
    int tot, k, acc, f, dr, lvl;

    always_comb begin
        e_busy = (m_st != S_IDLE);
        e_paused = (m_st == S_PAUSE);
        e_done = m_done;
        e_buzz = (m_st == S_ALARM);
        e_phase = '0;
        e_remain = '0;
        e_st = '0;
        e_wt = '0;
        tot = 0;
        acc = 0;
        f = 0;
        dr = 0;
        lvl = 0;
        for (int i = 0; i < NP; i++) tot += m_d[i];
        k = m_rc / TD;
        if (m_st == S_RUN || m_st == S_PAUSE) begin
            for (int i = 0; i < NP; i++) begin
                if (m_d[i] != 0 && k >= acc && k < acc + m_d[i]) begin
                    e_phase = 2'(i);
                    e_remain = CW'(acc + m_d[i] - k);
                end
                acc += m_d[i];
            end
            e_st[e_phase] = 1'b1;
        end
        if (m_st == S_ALARM)
            for (int i = 0; i < NP; i++)
                if (m_d[i] != 0) e_phase = 2'(i);
        if (m_st != S_IDLE) begin
            f = (k < m_d[0]) ? k : m_d[0];
            if (f > WW) f = WW;
            dr = k - (tot - m_d[NP-1]);
            if (dr < 0) dr = 0;
            if (dr > m_d[NP-1]) dr = m_d[NP-1];
            lvl = f - dr;
            if (lvl < 0) lvl = 0;
            e_wt = WW'((1 << lvl) - 1);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", busy, e_busy);
            chk("paused", paused, e_paused);
            chk("phase", phase, e_phase);
            chk("remain", remain, e_remain);
            chk("st_light", st_light, e_st);
            chk("wt_light", wt_light, e_wt);
            chk("done", done, e_done);
            chk("buzzer", buzzer, e_buzz);
        end
    end

    task automatic wait_done(output int e);
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", done, 1);
        e = ecnt;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        int n = 0;
        while (phase !== p && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_phase", phase, p);
    endtask

    task automatic count_buzz(input bit pz, output int b);
        b = 0;
        while (buzzer && b < 100) begin
            pause = pz && (b == 3);
            b++;
            @(negedge clk);
        end
        pause = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_wt", wt_light, 0);
        chk("ab_buzz", buzzer, 0);
        chk("ab_done", done, 0);
    endtask

    task automatic full_cycle(input string nm);
        int t0, t1, b;
        phase_mask = 4'b1111;
        phase_dur = {8'd3, 8'd2, 8'd2, 8'd1};
        do_start();
        t0 = ecnt;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_rem0"}, remain, 1);
        wait_done(t1);
        chk({nm, "_done_at"}, t1 - t0, 32);
        chk({nm, "_mdl_done"}, e_done, 1);
        count_buzz(1'b0, b);
        chk({nm, "_buzz_len"}, b, 12);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        int t0, t1, b, n;
        logic [3:0] seen;
        logic [7:0] wtor;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_phase", phase, 0);
        chk("rst_remain", remain, 0);
        chk("rst_wt", wt_light, 0);
        chk("rst_buzz", buzzer, 0);
        rst = 1'b1;
        @(negedge clk);

        full_cycle("t1");

        phase_mask = 4'b1011;
        phase_dur = {8'd1, 8'd5, 8'd2, 8'd0};
        do_start();
        t0 = ecnt;
        chk("t2_phase0", phase, 1);
        chk("t2_rem0", remain, 2);
        seen = '0;
        wtor = '0;
        n = 0;
        while (!done && n < 500) begin
            seen |= st_light;
            wtor |= wt_light;
            @(negedge clk);
            n++;
        end
        t1 = ecnt;
        chk("t2_seen", seen, 4'b1010);
        chk("t2_wt_never", wtor, 0);
        chk("t2_done_at", t1 - t0, 12);
        count_buzz(1'b0, b);
        chk("t2_buzz_len", b, 12);
        phase_mask = 4'b0000;
        do_start();
        chk("t2_empty", busy, 0);
        @(negedge clk);

        phase_mask = 4'b1001;
        phase_dur = {8'd3, 8'd0, 8'd0, 8'd10};
        do_start();
        t0 = ecnt;
        phase_dur = '0;
        phase_mask = '0;
        wait_phase(2'd3);
        chk("t3_full", wt_light, 8'hFF);
        wait_done(t1);
        chk("t3_done_at", t1 - t0, 52);
        chk("t3_drain", wt_light, 8'h1F);
        chk("t3_mdl_wt", e_wt, 8'h1F);
        count_buzz(1'b0, b);
        chk("t3_cleared", wt_light, 0);

        phase_mask = 4'b0011;
        phase_dur = {8'd0, 8'd0, 8'd2, 8'd1};
        do_start();
        t0 = ecnt;
        wait_phase(2'd1);
        repeat (2) @(negedge clk);
        chk("t4_rem", remain, 2);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        chk("t4_paused", paused, 1);
        repeat (19) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        chk("t4_resumed", paused, 0);
        wait_done(t1);
        chk("t4_done_at", t1 - t0, 32);
        count_buzz(1'b1, b);
        chk("t4_buzz_len", b, 12);

        phase_mask = 4'b1111;
        phase_dur = {8'd3, 8'd2, 8'd2, 8'd5};
        do_start();
        repeat (9) @(negedge clk);
        chk("t5_wt_pre", wt_light, 8'h03);
        do_abort();
        do_start();
        repeat (3) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        repeat (3) @(negedge clk);
        do_abort();
        chk("t5_unpaused", paused, 0);
        start = 1'b1;
        do_abort();
        start = 1'b0;
        do_start();
        repeat (7) @(negedge clk);
        do_abort();

        do_start();
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_phase", phase, 0);
        chk("t6_remain", remain, 0);
        chk("t6_st", st_light, 0);
        chk("t6_wt", wt_light, 0);
        chk("t6_buzz", buzzer, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        full_cycle("t6");

        for (int r = 0; r < 40; r++) begin
            phase_mask = 4'($urandom);
            for (int i = 0; i < NP; i++)
                phase_dur[i*CW +: CW] = 8'($urandom_range(0, 3));
            for (int c = 0; c < 120; c++) begin
                start = ($urandom_range(0, 9) == 0);
                pause = ($urandom_range(0, 14) == 0);
                abort = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 29) == 0)
                    phase_mask = 4'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
